// File: rtl/i2c_seq_engine.sv
// Register-write/read sequencer driving the 8-bit register port of an I2C master core.
// Build option I2C_SEQ_IRQ_EN: wait for m_irq instead of polling SR, with IACK on every command.
module i2c_seq_engine #(
   parameter logic [15:0] PRESCALE      = 16'd99,
   parameter logic [15:0] TIMEOUT_POLLS = 16'd4095
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_dev,
   input  logic [7:0] cmd_reg,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       rsp_al,
   output logic       rsp_err,
   output logic [2:0] m_address,
   output logic [7:0] m_writedata,
   input  logic [7:0] m_readdata,
   output logic       m_write,
   output logic       m_chipselect,
   input  logic       m_waitrequest_n,
   input  logic       m_irq
);
`ifdef I2C_SEQ_IRQ_EN
   localparam logic [7:0]  CTR_INIT = 8'hC0;
   localparam logic [7:0]  IACK     = 8'h01;
   localparam logic [19:0] TO_LIMIT = {TIMEOUT_POLLS, 4'h0};
`else
   localparam logic [7:0]  CTR_INIT = 8'h80;
   localparam logic [7:0]  IACK     = 8'h00;
   localparam logic [19:0] TO_LIMIT = {4'h0, TIMEOUT_POLLS};
`endif

   typedef enum logic [3:0] {
      S_INIT0, S_INIT1, S_INIT2, S_IDLE, S_TXR, S_CR, S_SR, S_CHK, S_RXR, S_STOP, S_DONE
   } state_t;

   state_t      state, next;
   logic        gap, acc_done, irq_ok, poll_to, wait_to, last_ph, data_ph;
   logic        rw_q;
   logic [6:0]  dev_q;
   logic [7:0]  reg_q, wd_q, sr_q, txr_byte, cr_byte;
   logic [1:0]  phase;
   logic [19:0] cnt;

   assign acc_done = m_chipselect & m_waitrequest_n;
   assign last_ph  = rw_q ? (phase == 2'd3) : (phase == 2'd2);
   assign data_ph  = rw_q & (phase == 2'd3);

`ifdef I2C_SEQ_IRQ_EN
   assign irq_ok  = m_irq;
   assign poll_to = 1'b0;
   assign wait_to = !m_irq && (cnt >= TO_LIMIT);
`else
   // m_irq has no effect in the polling build
   assign irq_ok  = m_irq | 1'b1;
   assign poll_to = (cnt >= TO_LIMIT);
   assign wait_to = 1'b0;
`endif

   always_comb begin
      case (phase)
         2'd0:    txr_byte = {dev_q, 1'b0};
         2'd1:    txr_byte = reg_q;
         default: txr_byte = rw_q ? {dev_q, 1'b1} : wd_q;
      endcase
      case (phase)
         2'd0:    cr_byte = 8'h90 | IACK;
         2'd1:    cr_byte = 8'h10 | IACK;
         2'd2:    cr_byte = (rw_q ? 8'h90 : 8'h50) | IACK;
         default: cr_byte = 8'h68 | IACK;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_INIT0;
         gap       <= 1'b1;
         rw_q      <= 1'b0;
         dev_q     <= '0;
         reg_q     <= '0;
         wd_q      <= '0;
         sr_q      <= '0;
         phase     <= '0;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_nack  <= 1'b0;
         rsp_al    <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         state <= next;
         // chipselect must drop for a cycle after every completed access
         gap   <= acc_done;
         case (state)
            S_IDLE: if (cmd_valid) begin
               rw_q     <= cmd_rw;
               dev_q    <= cmd_dev;
               reg_q    <= cmd_reg;
               wd_q     <= cmd_wdata;
               phase    <= '0;
               rsp_nack <= 1'b0;
               rsp_al   <= 1'b0;
               rsp_err  <= 1'b0;
            end
            S_CR: if (acc_done) cnt <= '0;
            S_SR: begin
               if (acc_done) sr_q <= m_readdata;
`ifdef I2C_SEQ_IRQ_EN
               if (!m_irq) cnt <= cnt + 20'd1;
`else
               if (acc_done) cnt <= cnt + 20'd1;
`endif
               if (wait_to) rsp_err <= 1'b1;
            end
            S_CHK: begin
               if (sr_q[5])                 rsp_al   <= 1'b1;
               else if (sr_q[1])            rsp_err  <= poll_to;
               else if (sr_q[7] && !data_ph) rsp_nack <= 1'b1;
               else if (!last_ph)           phase    <= phase + 2'd1;
            end
            S_RXR: if (acc_done) rsp_rdata <= m_readdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      next = state;
      case (state)
         S_INIT0: if (acc_done) next = S_INIT1;
         S_INIT1: if (acc_done) next = S_INIT2;
         S_INIT2: if (acc_done) next = S_IDLE;
         S_IDLE:  if (cmd_valid) next = S_TXR;
         S_TXR:   if (acc_done) next = S_CR;
         S_CR:    if (acc_done) next = S_SR;
         S_SR:    if (acc_done) next = S_CHK; else if (wait_to) next = S_STOP;
         S_CHK: begin
            if (sr_q[5])                  next = S_DONE;
            else if (sr_q[1])             next = poll_to ? S_STOP : S_SR;
            else if (sr_q[7] && !data_ph) next = S_STOP;
            else if (last_ph)             next = rw_q ? S_RXR : S_DONE;
            else                          next = (rw_q && phase == 2'd2) ? S_CR : S_TXR;
         end
         S_RXR:   if (acc_done) next = S_DONE;
         S_STOP:  if (acc_done) next = S_DONE;
         S_DONE:  next = S_IDLE;
         default: next = S_INIT0;
      endcase
   end

   always_comb begin
      m_chipselect = 1'b0;
      m_address    = '0;
      m_writedata  = '0;
      m_write      = 1'b0;
      case (state)
         S_INIT0: begin m_chipselect = !gap; m_address = 3'd0; m_writedata = PRESCALE[7:0];  m_write = 1'b1; end
         S_INIT1: begin m_chipselect = !gap; m_address = 3'd1; m_writedata = PRESCALE[15:8]; m_write = 1'b1; end
         S_INIT2: begin m_chipselect = !gap; m_address = 3'd2; m_writedata = CTR_INIT;       m_write = 1'b1; end
         S_TXR:   begin m_chipselect = !gap; m_address = 3'd3; m_writedata = txr_byte;       m_write = 1'b1; end
         S_CR:    begin m_chipselect = !gap; m_address = 3'd4; m_writedata = cr_byte;        m_write = 1'b1; end
         S_STOP:  begin m_chipselect = !gap; m_address = 3'd4; m_writedata = 8'h40 | IACK;   m_write = 1'b1; end
         S_SR:    begin m_chipselect = !gap && irq_ok; m_address = 3'd4; end
         S_RXR:   begin m_chipselect = !gap; m_address = 3'd3; end
         default: ;
      endcase
      if (!m_chipselect) begin
         m_address   = '0;
         m_writedata = '0;
         m_write     = 1'b0;
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_DONE);
endmodule

// File: tb/tb_i2c_seq_engine.sv
// Directed bench for i2c_seq_engine: a register-port slave model logs every completed access.
module tb_i2c_seq_engine;
   logic       clk = 1'b0, reset_n = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
   logic [6:0] cmd_dev = '0;
   logic [7:0] cmd_reg = '0, cmd_wdata = '0;
   logic       rsp_valid, rsp_nack, rsp_al, rsp_err;
   logic [7:0] rsp_rdata;
   logic [2:0] m_address;
   logic [7:0] m_writedata, m_readdata;
   logic       m_write, m_chipselect, wrn, m_irq = 1'b0;

   logic [7:0]  sr_val = 8'h00, rxr_val = 8'h00;
   logic        hold = 1'b0;
   int          st_cnt = 0;
   logic [11:0] log_q[$];
   logic [11:0] stall_q[$];
   logic [11:0] exp_q[$];
   int          n_cmp = 0, n_bad = 0, n_rsp = 0;
   logic        r_nack = 1'b0, r_al = 1'b0, r_err = 1'b0;

   always #5 clk = ~clk;

   i2c_seq_engine dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
      .rsp_al(rsp_al), .rsp_err(rsp_err),
      .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
      .m_write(m_write), .m_chipselect(m_chipselect),
      .m_waitrequest_n(wrn), .m_irq(m_irq)
   );

   assign m_readdata = (m_address == 3'd4) ? sr_val : (m_address == 3'd3) ? rxr_val : 8'h00;
   always_comb wrn = !(hold && m_chipselect && m_address == 3'd3 && m_write && st_cnt < 5);

   always @(posedge clk) begin
      if (!hold) st_cnt <= 0;
      else if (m_chipselect && !wrn) st_cnt <= st_cnt + 1;
   end

   always @(negedge clk) begin
      if (m_chipselect && wrn)  log_q.push_back({m_write, m_address, m_write ? m_writedata : m_readdata});
      if (m_chipselect && !wrn) stall_q.push_back({m_write, m_address, m_writedata});
      if (rsp_valid) begin
         n_rsp  <= n_rsp + 1;
         r_nack <= rsp_nack;
         r_al   <= rsp_al;
         r_err  <= rsp_err;
      end
   end

   function automatic logic [11:0] wr_ent(input logic [2:0] a, input logic [7:0] d);
      return {1'b1, a, d};
   endfunction
   function automatic logic [11:0] rd_ent(input logic [2:0] a, input logic [7:0] d);
      return {1'b0, a, d};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_log(input string tag);
      chk({tag, "_len"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s_acc%0d", tag, i), log_q[i], exp_q[i]);
   endtask

   task automatic wait_ready();
      int i = 0;
      while (!cmd_ready && i < 200) begin @(negedge clk); i++; end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic start_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
      wait_ready();
      log_q.delete();
      stall_q.delete();
      exp_q.delete();
      cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int prev);
      int i = 0;
      while (n_rsp == prev && i < 20000) begin @(negedge clk); i++; end
      if (n_rsp == prev) chk("rsp_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int prev, nsr;
      repeat (3) @(negedge clk);
      chk("rst_outs", {m_chipselect, m_write, m_address, m_writedata, cmd_ready, rsp_valid,
                       rsp_nack, rsp_al, rsp_err, rsp_rdata}, 0);
      reset_n = 1'b1;
      wait_ready();
      exp_q = '{wr_ent(0, 8'h63), wr_ent(1, 8'h00), wr_ent(2, 8'h80)};
      chk_log("init");
      chk("init_rsp", {rsp_valid, rsp_nack, rsp_al, rsp_err}, 0);

      // register write, clean ACKs
      prev = n_rsp;
      start_cmd(1'b0, 7'h50, 8'h12, 8'hA5);
      wait_rsp(prev);
      exp_q = '{wr_ent(3, 8'hA0), wr_ent(4, 8'h90), rd_ent(4, 8'h00),
                wr_ent(3, 8'h12), wr_ent(4, 8'h10), rd_ent(4, 8'h00),
                wr_ent(3, 8'hA5), wr_ent(4, 8'h50), rd_ent(4, 8'h00)};
      chk_log("wr");
      chk("wr_nrsp", n_rsp, prev + 1);
      chk("wr_flags", {r_nack, r_al, r_err}, 0);

      // register read
      rxr_val = 8'h3C;
      prev = n_rsp;
      start_cmd(1'b1, 7'h50, 8'h12, 8'h00);
      wait_rsp(prev);
      exp_q = '{wr_ent(3, 8'hA0), wr_ent(4, 8'h90), rd_ent(4, 8'h00),
                wr_ent(3, 8'h12), wr_ent(4, 8'h10), rd_ent(4, 8'h00),
                wr_ent(3, 8'hA1), wr_ent(4, 8'h90), rd_ent(4, 8'h00),
                wr_ent(4, 8'h68), rd_ent(4, 8'h00), rd_ent(3, 8'h3C)};
      chk_log("rd");
      chk("rd_rdata", rsp_rdata, 8'h3C);
      chk("rd_flags", {r_nack, r_al, r_err}, 0);

      // address NACK: STOP and no further TXR
      sr_val = 8'h80;
      rxr_val = 8'h99;
      prev = n_rsp;
      start_cmd(1'b1, 7'h33, 8'h01, 8'h00);
      wait_rsp(prev);
      exp_q = '{wr_ent(3, 8'h66), wr_ent(4, 8'h90), rd_ent(4, 8'h80), wr_ent(4, 8'h40)};
      chk_log("nack");
      chk("nack_flags", {r_nack, r_al, r_err}, 3'b100);
      chk("nack_rdata", rsp_rdata, 8'h3C);

      // arbitration lost: no STOP
      sr_val = 8'h20;
      prev = n_rsp;
      start_cmd(1'b0, 7'h11, 8'h02, 8'h03);
      wait_rsp(prev);
      exp_q = '{wr_ent(3, 8'h22), wr_ent(4, 8'h90), rd_ent(4, 8'h20)};
      chk_log("al");
      chk("al_flags", {r_nack, r_al, r_err}, 3'b010);

      // TIP stuck: poll timeout
      sr_val = 8'h02;
      prev = n_rsp;
      start_cmd(1'b0, 7'h50, 8'h12, 8'hA5);
      wait_rsp(prev);
      nsr = 0;
      foreach (log_q[i]) if (log_q[i] == rd_ent(4, 8'h02)) nsr++;
      chk("to_polls", nsr, 4095);
      chk("to_len", log_q.size(), 4098);
      if (log_q.size() > 0) chk("to_stop", log_q[log_q.size()-1], wr_ent(4, 8'h40));
      chk("to_flags", {r_nack, r_al, r_err}, 3'b001);

      // stalled TXR write with an overlapping cmd_valid
      sr_val = 8'h00;
      hold = 1'b1;
      prev = n_rsp;
      start_cmd(1'b0, 7'h21, 8'h34, 8'h56);
      cmd_rw = 1'b1; cmd_dev = 7'h7F; cmd_reg = 8'hEE; cmd_valid = 1'b1;
      repeat (2) @(negedge clk);
      cmd_valid = 1'b0;
      wait_rsp(prev);
      hold = 1'b0;
      chk("hold_stalls", stall_q.size(), 5);
      foreach (stall_q[i]) chk($sformatf("hold_stable%0d", i), stall_q[i], wr_ent(3, 8'h42));
      exp_q = '{wr_ent(3, 8'h42), wr_ent(4, 8'h90), rd_ent(4, 8'h00),
                wr_ent(3, 8'h34), wr_ent(4, 8'h10), rd_ent(4, 8'h00),
                wr_ent(3, 8'h56), wr_ent(4, 8'h50), rd_ent(4, 8'h00)};
      chk_log("hold");
      repeat (20) @(negedge clk);
      chk("hold_nrsp", n_rsp, prev + 1);
      chk("hold_flags", {r_nack, r_al, r_err}, 0);
      chk("hold_ready", cmd_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
